// File: rtl/note_tick_gen.sv
// note_tick_gen
//   Tone-timing stage. For each accepted note it emits `duration` one-cycle
//   tick pulses spaced `half_period` cycles apart. It also drives a square-wave
//   level that toggles on every tick, and a one-cycle done pulse when the note
//   completes normally.
//
// Handshake: a note is accepted when start=1 is sampled while the block is
//   idle (busy=0). busy stays high from the edge that accepts the note until
//   the block is idle again. start is ignored while busy. done pulses for
//   exactly one cycle at normal completion and never after abort.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          asynchronous active-high reset
//   start        note request, sampled only in IDLE
//   half_period  cycles between ticks, sampled with start
//   duration     number of ticks to emit, sampled with start
//   abort        drop the current note, no done pulse
//   tick         one-cycle enable pulse for the downstream flop stage
//   tone         square-wave level, toggles on each tick
//   busy         note in progress
//   done         one-cycle pulse at normal completion
//   dbg_state    current FSM state (0 IDLE, 1 PLAY, 2 DONE)
module note_tick_gen #(
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PERIOD_W-1:0] half_period,
  input  logic [DUR_W-1:0]    duration,
  input  logic                abort,
  output logic                tick,
  output logic                tone,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] hp_q, hp_d;
  logic [DUR_W-1:0]    left_q, left_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                tick_q, tick_d;
  logic                tone_q, tone_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // hp_q is at least 1 whenever PLAY is active, so this never wraps there.
  logic [PERIOD_W-1:0] hp_m1;
  assign hp_m1 = hp_q - PERIOD_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hp_q    <= '0;
      left_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The output registers are loaded with the values that belong to the next
  // state, so the outputs always line up with the state register.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    left_d  = left_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    tone_d  = tone_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        tone_d = 1'b0;
        // abort is deliberately ignored here, so start wins over abort.
        if (start) begin
          busy_d = 1'b1;
          if (half_period != '0 && duration != '0) begin
            hp_d    = half_period;
            left_d  = duration;
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            // A zero-length note completes immediately without any ticks.
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      PLAY: begin
        busy_d = 1'b1;
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          tone_d  = 1'b0;
          cnt_d   = '0;
          left_d  = '0;
        end else if (left_q == '0) begin
          // The final tick is being driven this cycle. Completion follows it.
          state_d = DONE;
          done_d  = 1'b1;
          tone_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == hp_m1) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          tone_d = ~tone_q;
          left_d = left_q - DUR_W'(1);
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end

      DONE: begin
        // DONE lasts one cycle whether or not abort is high.
        state_d = IDLE;
        busy_d  = 1'b0;
        tone_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tone_d  = 1'b0;
      end
    endcase
  end

  assign tick      = tick_q;
  assign tone      = tone_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
